// File: rtl/timer_cmp.sv
// timer_cmp: Count/Compare timer interrupt with a saturating hit counter; TIMER_PERIODIC_EN adds periodic re-arm
module timer_cmp #(
  parameter int WIDTH = 32,
  parameter int HITW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             ack,
  output logic             irq
);
`ifdef TIMER_PERIODIC_EN
  localparam logic PER = 1'b1;
`else
  localparam logic PER = 1'b0;
`endif
  logic [WIDTH-1:0] compare, per_rd;
  logic [1:0]       ctrl;
  logic             pending;
  logic [HITW-1:0]  hit_cnt;
  logic             match, wr_cmp, wr_st, adv;
  assign match  = ctrl[0] && count_in == compare;
  assign wr_cmp = we && addr == 2'd0;
  assign wr_st  = we && addr == 2'd3;
  assign adv    = match && ctrl[1] && |per_rd;
  assign irq    = pending;
`ifdef TIMER_PERIODIC_EN
  logic [WIDTH-1:0] period;
  assign per_rd = period;
  // period register, software written only
  always_ff @(posedge clk or negedge rst)
    if (!rst) period <= '0;
    else if (we && addr == 2'd2) period <= wdata;
`else
  assign per_rd = '0;
`endif
  // compare: software write wins over the periodic advance
  always_ff @(posedge clk or negedge rst)
    if (!rst) compare <= '1;
    else compare <= wr_cmp ? wdata : adv ? compare + per_rd : compare;
  // ctrl: en always, periodic only when the feature is built in
  always_ff @(posedge clk or negedge rst)
    if (!rst) ctrl <= '0;
    else if (we && addr == 2'd1) ctrl <= {PER & wdata[1], wdata[0]};
  // pending: compare write clears and masks the match; match beats ack / w1c
  always_ff @(posedge clk or negedge rst)
    if (!rst) pending <= 1'b0;
    else pending <= wr_cmp ? 1'b0 : match ? 1'b1 : (ack || (wr_st && wdata[0])) ? 1'b0 : pending;
  // hit_cnt: saturating; a compare write suppresses the match, status bit1 clears
  always_ff @(posedge clk or negedge rst)
    if (!rst) hit_cnt <= '0;
    else if (wr_st && wdata[1]) hit_cnt <= '0;
    else if (match && !wr_cmp && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
  // register read mux
  always_comb
    rdata = addr == 2'd0 ? compare :
            addr == 2'd1 ? WIDTH'(ctrl) :
            addr == 2'd2 ? per_rd :
            WIDTH'({hit_cnt, 7'b0, pending});
endmodule

// File: tb/tb_timer_cmp.sv
// tb_timer_cmp: directed vectors, corner sequences and a random run against a reference model
module tb_timer_cmp;
`ifdef TIMER_PERIODIC_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif
  logic        clk = 0, rst = 0, we = 0, ack = 0, irq;
  logic [1:0]  addr = 0;
  logic [31:0] count_in = 0, wdata = 0, rdata;
  int tests = 0, fails = 0;

  timer_cmp dut (.clk(clk), .rst(rst), .count_in(count_in), .we(we), .addr(addr),
                 .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq));

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [1:0] a; logic [31:0] wd; logic [31:0] cnt; logic ack;
    logic [1:0] ra; logic irq; logic [31:0] rd;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic [1:0] a, input logic [31:0] wd, input logic [31:0] cnt,
                     input logic k, input logic [1:0] ra, input logic i, input logic [31:0] rd);
    v.push_back('{w, a, wd, cnt, k, ra, i, rd});
  endtask

  task automatic drive(input logic w, input logic [1:0] a, input logic [31:0] wd, input logic [31:0] cnt, input logic k);
    we = w; addr = a; wdata = wd; count_in = cnt; ack = k;
    tick;
    we = 0; ack = 0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  // reference model state
  logic [31:0] m_cmp, m_period;
  logic        m_en, m_periodic, m_pend;
  int          m_hit;

  function automatic logic [31:0] mread(input logic [1:0] a);
    case (a)
      2'd0: return m_cmp;
      2'd1: return {30'b0, m_periodic, m_en};
      2'd2: return m_period;
      default: return {16'b0, 8'(m_hit), 7'b0, m_pend};
    endcase
  endfunction

  initial begin
    tick; tick;
    addr = 0;
    #1;
    chk("reset_irq", {31'b0, irq}, 0);
    chk("reset_compare", rdata, 32'hFFFF_FFFF);
    #2 rst = 1;
    tick;
    chk("post_reset_compare", rdata, 32'hFFFF_FFFF);
    chk("post_reset_irq", {31'b0, irq}, 0);

    add(1, 0, 100, 0, 0, 0, 0, 100);
    add(1, 1, 1, 90, 0, 1, 0, 1);
    add(0, 0, 0, 99, 0, 3, 0, 32'h000);
    add(0, 0, 0, 100, 0, 3, 1, 32'h101);
    add(0, 0, 0, 101, 0, 3, 1, 32'h101);
    add(0, 0, 0, 102, 1, 3, 0, 32'h100);
    add(0, 0, 0, 100, 1, 3, 1, 32'h201);
    add(1, 3, 1, 5, 0, 3, 0, 32'h200);
    add(1, 0, 50, 7, 0, 0, 0, 50);
    add(1, 0, 200, 50, 0, 0, 0, 200);
    add(0, 0, 0, 51, 0, 3, 0, 32'h200);
    add(1, 0, 2, 32'hFFFF_FFFE, 0, 0, 0, 2);
    add(0, 0, 0, 32'hFFFF_FFFF, 0, 3, 0, 32'h200);
    add(0, 0, 0, 0, 0, 3, 0, 32'h200);
    add(0, 0, 0, 1, 0, 3, 0, 32'h200);
    add(0, 0, 0, 2, 0, 3, 1, 32'h301);
    add(0, 0, 0, 3, 0, 3, 1, 32'h301);
    add(1, 3, 1, 9, 0, 3, 0, 32'h300);
    add(1, 1, 0, 2, 0, 3, 1, 32'h401);
    add(1, 3, 1, 2, 0, 3, 0, 32'h400);
    add(1, 3, 2, 2, 0, 3, 0, 32'h000);
    add(1, 1, 32'hFFFF_FFFF, 2, 0, 1, 0, PER ? 3 : 1);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 2, 32'h20, 0, 0, 2, 0, PER ? 32'h20 : 0);
    foreach (v[i]) begin
      drive(v[i].we, v[i].a, v[i].wd, v[i].cnt, v[i].ack);
      addr = v[i].ra;
      #1;
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, v[i].irq});
      chk($sformatf("vec%0d_rdata", i), rdata, v[i].rd);
    end

    // saturation: 300 matches, each on a freshly written compare
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 1000 + i, 0, 0);
      drive(0, 0, 0, 1000 + i, 0);
    end
    rd("sat_status", 3, 32'hFF01);
    chk("sat_irq", {31'b0, irq}, 1);
    drive(1, 3, 2, 0, 0);
    rd("hit_clear", 3, 32'h0001);
    drive(0, 0, 0, 0, 1);
    chk("ack_irq", {31'b0, irq}, 0);

    // periodic re-arm across the 32-bit wrap
    drive(1, 3, 3, 0, 0);
    drive(1, 0, 32'hFFFF_FFF0, 0, 0);
    drive(1, 2, 32'h20, 0, 0);
    drive(1, 1, 3, 0, 0);
    drive(0, 0, 0, 32'hFFFF_FFF0, 0);
    chk("per_irq1", {31'b0, irq}, 1);
    rd("per_cmp1", 0, PER ? 32'h10 : 32'hFFFF_FFF0);
    rd("per_hit1", 3, 32'h101);
    drive(0, 0, 0, 5, 1);
    chk("per_ack", {31'b0, irq}, 0);
    drive(0, 0, 0, 32'h10, 0);
    chk("per_irq2", {31'b0, irq}, {31'b0, PER});
    rd("per_hit2", 3, PER ? 32'h201 : 32'h100);
    rd("per_cmp2", 0, PER ? 32'h30 : 32'hFFFF_FFF0);
    rd("per_read", 2, PER ? 32'h20 : 0);

    // asynchronous reset while irq is high
    drive(1, 0, 7, 0, 0);
    drive(0, 0, 0, 7, 0);
    chk("pre_rst_irq", {31'b0, irq}, 1);
    #1 rst = 0;
    #1;
    chk("async_rst_irq", {31'b0, irq}, 0);
    rd("async_rst_cmp", 0, 32'hFFFF_FFFF);
    rd("async_rst_status", 3, 0);
    #1 rst = 1;
    drive(0, 0, 0, 32'hFFFF_FFFF, 0);
    chk("rst_en_off", {31'b0, irq}, 0);

    // random run against the reference model
    m_cmp = 32'hFFFF_FFFF; m_period = 0; m_en = 0; m_periodic = 0; m_pend = 0; m_hit = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r_we, r_ack, hit;
      logic [1:0]  r_a;
      logic [31:0] r_wd, r_cnt;
      r_we  = $urandom_range(0, 3) == 0;
      r_a   = 2'($urandom_range(0, 3));
      r_wd  = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 15);
      r_cnt = $urandom_range(0, 15);
      r_ack = $urandom_range(0, 7) == 0;
      hit = m_en && r_cnt == m_cmp;
      we = r_we; addr = r_a; wdata = r_wd; count_in = r_cnt; ack = r_ack;
      @(posedge clk);
      if (r_we && r_a == 0) begin
        m_cmp = r_wd;
        m_pend = 0;
      end else if (hit) begin
        m_pend = 1;
        m_hit = m_hit < 255 ? m_hit + 1 : 255;
        if (m_periodic && m_period != 0) m_cmp = m_cmp + m_period;
      end else if (r_ack || (r_we && r_a == 3 && r_wd[0])) m_pend = 0;
      if (r_we && r_a == 3 && r_wd[1]) m_hit = 0;
      if (r_we && r_a == 1) begin
        m_en = r_wd[0];
        m_periodic = PER && r_wd[1];
      end
      if (PER && r_we && r_a == 2) m_period = r_wd;
      #1;
      chk("rand_irq", {31'b0, irq}, {31'b0, m_pend});
      chk("rand_rdata", rdata, mread(r_a));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
